// File: rtl/cpu_to_fpga_dma.sv
// cpu_to_fpga_dma: reads host buffers over the PCIe BAS read port and
// streams them out as 64-byte flits with sop/eop framing, then reports one
// completion per transfer.
// Optional feature macro: C2F_PAGE_SPLIT_EN (bursts never cross a 4 KiB page).
module cpu_to_fpga_dma #(
    parameter int MAX_BURST   = 8,
    parameter int RESP_DEPTH  = 64,
    parameter int COMPL_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sw_reset,
    input  logic [63:0]  req_addr,
    input  logic [31:0]  req_length,
    input  logic [63:0]  req_desc_addr,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         pcie_bas_waitrequest,
    output logic [63:0]  pcie_bas_address,
    output logic [63:0]  pcie_bas_byteenable,
    output logic         pcie_bas_read,
    output logic [3:0]   pcie_bas_burstcount,
    input  logic [511:0] pcie_bas_readdata,
    input  logic         pcie_bas_readdatavalid,
    input  logic [1:0]   pcie_bas_response,
    output logic         pcie_bas_write,
    output logic [511:0] out_data,
    output logic         out_sop,
    output logic         out_eop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  compl_transfer_addr,
    output logic [31:0]  compl_length,
    output logic [63:0]  compl_descriptor_addr,
    output logic         compl_valid,
    input  logic         compl_ready,
    output logic [31:0]  rd_stall_cnt,
    output logic [31:0]  rsp_err_cnt
);
    localparam int RPW = $clog2(RESP_DEPTH);
    localparam int RCW = $clog2(RESP_DEPTH + 1);
    localparam int TPW = $clog2(COMPL_DEPTH);
    localparam int TCW = $clog2(COMPL_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t          state;
    logic [63:0]     cur_addr;
    logic [26:0]     remaining;
    logic [RCW-1:0]  credits;
    logic [RCW-1:0]  pending;
    logic [26:0]     req_flits;
    logic [26:0]     page_lim;
    logic [26:0]     burst_wide;
    logic [3:0]      burst;
    logic            issue;
    logic            rdv_acc;

    // response FIFO
    logic [511:0]    resp_mem [RESP_DEPTH];
    logic [RPW-1:0]  resp_wr, resp_rd;
    logic [RCW-1:0]  resp_count;

    // completion-tracking FIFO
    logic [63:0]     trk_addr  [COMPL_DEPTH];
    logic [31:0]     trk_len   [COMPL_DEPTH];
    logic [63:0]     trk_desc  [COMPL_DEPTH];
    logic [26:0]     trk_flits [COMPL_DEPTH];
    logic [TPW-1:0]  trk_wr, trk_rd;
    logic [TCW-1:0]  trk_count, trk_count_nxt;
    logic            trk_push, trk_pop;

    logic [26:0]     pos;
    logic [26:0]     head_flits;
    logic            trk_empty;
    logic            is_last;
    logic            flit_pop;
    logic            zero_move;

    assign pcie_bas_write      = 1'b0;
    assign pcie_bas_byteenable = '1;

    assign req_flits = {1'b0, req_length[31:6]} + 27'(|req_length[5:0]);

`ifdef C2F_PAGE_SPLIT_EN
    assign page_lim = 27'd64 - 27'(cur_addr[11:6]);
`else
    assign page_lim = 27'(MAX_BURST);
`endif

    // burst size: min(remaining flits, MAX_BURST, page limit)
    always_comb begin
        burst_wide = remaining;
        if (burst_wide > 27'(MAX_BURST)) burst_wide = 27'(MAX_BURST);
        if (burst_wide > page_lim)       burst_wide = page_lim;
    end
    assign burst = 4'(burst_wide);

    assign issue    = (state == ISSUE) && (credits >= RCW'(burst));
    assign rdv_acc  = pcie_bas_readdatavalid && (pending != '0) &&
                      (resp_count < RCW'(RESP_DEPTH));
    assign trk_push = req_valid && req_ready;

    assign trk_empty  = (trk_count == '0);
    assign head_flits = trk_flits[trk_rd];
    assign is_last    = (pos == head_flits - 27'd1);
    assign out_valid  = (resp_count != '0) && !trk_empty && (head_flits != '0) &&
                        (!is_last || !compl_valid);
    assign out_data   = resp_mem[resp_rd];
    assign out_sop    = (pos == '0);
    assign out_eop    = is_last;
    assign flit_pop   = out_valid && out_ready;
    assign zero_move  = !trk_empty && (head_flits == '0) && !compl_valid;
    assign trk_pop    = (flit_pop && is_last) || zero_move;
    assign trk_count_nxt = trk_count + TCW'(trk_push) - TCW'(trk_pop);

    // request FSM, read issue, credit and outstanding-flit accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            req_ready           <= 1'b0;
            pcie_bas_read       <= 1'b0;
            pcie_bas_address    <= '0;
            pcie_bas_burstcount <= '0;
            cur_addr            <= '0;
            remaining           <= '0;
            credits             <= RCW'(RESP_DEPTH);
            pending             <= '0;
        end else begin
            credits   <= credits - (issue ? RCW'(burst) : '0) + (flit_pop ? RCW'(1) : '0);
            pending   <= pending + (issue ? RCW'(burst) : '0) - (rdv_acc ? RCW'(1) : '0);
            req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (trk_push && req_flits != '0) begin
                        state     <= ISSUE;
                        cur_addr  <= req_addr;
                        remaining <= req_flits;
                    end else begin
                        req_ready <= (trk_count_nxt < TCW'(COMPL_DEPTH));
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        pcie_bas_read       <= 1'b1;
                        pcie_bas_address    <= cur_addr;
                        pcie_bas_burstcount <= burst;
                        state               <= HOLD;
                    end
                end
                HOLD: begin
                    if (!pcie_bas_waitrequest) begin
                        pcie_bas_read <= 1'b0;
                        remaining     <= remaining - 27'(pcie_bas_burstcount);
                        cur_addr      <= cur_addr + {54'd0, pcie_bas_burstcount, 6'd0};
                        if (remaining == 27'(pcie_bas_burstcount)) begin
                            state     <= IDLE;
                            req_ready <= (trk_count_nxt < TCW'(COMPL_DEPTH));
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // response FIFO storage
    always_ff @(posedge clk) begin
        if (rdv_acc) resp_mem[resp_wr] <= pcie_bas_readdata;
    end

    // response FIFO pointers; stray flits with no burst outstanding are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_wr    <= '0;
            resp_rd    <= '0;
            resp_count <= '0;
        end else begin
            if (rdv_acc)  resp_wr <= (resp_wr == RPW'(RESP_DEPTH - 1)) ? '0 : resp_wr + 1'b1;
            if (flit_pop) resp_rd <= (resp_rd == RPW'(RESP_DEPTH - 1)) ? '0 : resp_rd + 1'b1;
            resp_count <= resp_count + RCW'(rdv_acc) - RCW'(flit_pop);
        end
    end

    // tracking FIFO storage, written on request accept
    always_ff @(posedge clk) begin
        if (trk_push) begin
            trk_addr[trk_wr]  <= req_addr;
            trk_len[trk_wr]   <= req_length;
            trk_desc[trk_wr]  <= req_desc_addr;
            trk_flits[trk_wr] <= req_flits;
        end
    end

    // tracking FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_wr    <= '0;
            trk_rd    <= '0;
            trk_count <= '0;
        end else begin
            if (trk_push) trk_wr <= (trk_wr == TPW'(COMPL_DEPTH - 1)) ? '0 : trk_wr + 1'b1;
            if (trk_pop)  trk_rd <= (trk_rd == TPW'(COMPL_DEPTH - 1)) ? '0 : trk_rd + 1'b1;
            trk_count <= trk_count_nxt;
        end
    end

    // flit position within the head transfer and the completion register
    always_ff @(posedge clk) begin
        if (rst) begin
            pos                   <= '0;
            compl_valid           <= 1'b0;
            compl_transfer_addr   <= '0;
            compl_length          <= '0;
            compl_descriptor_addr <= '0;
        end else begin
            if (flit_pop) pos <= is_last ? '0 : pos + 27'd1;
            if (trk_pop) begin
                compl_valid           <= 1'b1;
                compl_transfer_addr   <= trk_addr[trk_rd];
                compl_length          <= trk_len[trk_rd];
                compl_descriptor_addr <= trk_desc[trk_rd];
            end else if (compl_ready) begin
                compl_valid <= 1'b0;
            end
        end
    end

    // saturating stall and error counters
    always_ff @(posedge clk) begin
        if (rst || sw_reset) begin
            rd_stall_cnt <= '0;
            rsp_err_cnt  <= '0;
        end else begin
            if (pcie_bas_read && pcie_bas_waitrequest && rd_stall_cnt != '1)
                rd_stall_cnt <= rd_stall_cnt + 32'd1;
            if (rdv_acc && pcie_bas_response != 2'd0 && rsp_err_cnt != '1)
                rsp_err_cnt <= rsp_err_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_cpu_to_fpga_dma.sv
// Scoreboard bench for cpu_to_fpga_dma: a BAS slave model returns data,
// expected bursts, flits and completions are queued when requests are sent.
module tb_cpu_to_fpga_dma;
    localparam int MAX_BURST   = 8;
    localparam int RESP_DEPTH  = 64;
    localparam int COMPL_DEPTH = 4;

    logic         clk, rst, sw_reset;
    logic [63:0]  req_addr, req_desc_addr;
    logic [31:0]  req_length;
    logic         req_valid, req_ready;
    logic         pcie_bas_waitrequest;
    logic [63:0]  pcie_bas_address, pcie_bas_byteenable;
    logic         pcie_bas_read;
    logic [3:0]   pcie_bas_burstcount;
    logic [511:0] pcie_bas_readdata;
    logic         pcie_bas_readdatavalid;
    logic [1:0]   pcie_bas_response;
    logic         pcie_bas_write;
    logic [511:0] out_data;
    logic         out_sop, out_eop, out_valid, out_ready;
    logic [63:0]  compl_transfer_addr, compl_descriptor_addr;
    logic [31:0]  compl_length;
    logic         compl_valid, compl_ready;
    logic [31:0]  rd_stall_cnt, rsp_err_cnt;

    cpu_to_fpga_dma #(.MAX_BURST(MAX_BURST), .RESP_DEPTH(RESP_DEPTH), .COMPL_DEPTH(COMPL_DEPTH)) dut (
        .clk(clk), .rst(rst), .sw_reset(sw_reset),
        .req_addr(req_addr), .req_length(req_length), .req_desc_addr(req_desc_addr),
        .req_valid(req_valid), .req_ready(req_ready),
        .pcie_bas_waitrequest(pcie_bas_waitrequest), .pcie_bas_address(pcie_bas_address),
        .pcie_bas_byteenable(pcie_bas_byteenable), .pcie_bas_read(pcie_bas_read),
        .pcie_bas_burstcount(pcie_bas_burstcount), .pcie_bas_readdata(pcie_bas_readdata),
        .pcie_bas_readdatavalid(pcie_bas_readdatavalid), .pcie_bas_response(pcie_bas_response),
        .pcie_bas_write(pcie_bas_write),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .compl_transfer_addr(compl_transfer_addr), .compl_length(compl_length),
        .compl_descriptor_addr(compl_descriptor_addr), .compl_valid(compl_valid),
        .compl_ready(compl_ready), .rd_stall_cnt(rd_stall_cnt), .rsp_err_cnt(rsp_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [519:0] got, input logic [519:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboards
    logic [67:0]  exp_burst [$];
    logic [513:0] exp_flit  [$];
    logic [159:0] exp_compl [$];
    logic [63:0]  rd_q      [$];

    longint issued_flits = 0;
    longint popped_flits = 0;
    int     burst_seen   = 0;
    int     stall_target = -1;
    int     stall_left   = 0;
    int     out_mode     = 0;   // 0 ready, 1 stalled, 2 random
    int     compl_mode   = 0;
    logic [63:0] err_addr = '1;

    function automatic logic [511:0] data_of(input logic [63:0] a);
        logic [511:0] d;
        for (int i = 0; i < 8; i++)
            d[i*64 +: 64] = a ^ (64'h0123_4567_89AB_CDEF * 64'(i + 1));
        return d;
    endfunction

    task automatic send(input logic [63:0] a, input logic [31:0] len, input logic [63:0] desc);
        longint n, rem, b, lim;
        logic [63:0] ba;
        int t;
        n = (longint'(len) + 63) / 64;
        for (longint i = 0; i < n; i++)
            exp_flit.push_back({data_of(a + 64'(64 * i)), (i == 0), (i == n - 1)});
        ba = a;
        rem = n;
        while (rem > 0) begin
            b = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef C2F_PAGE_SPLIT_EN
            lim = (4096 - longint'(ba[11:0])) / 64;
            if (b > lim) b = lim;
`else
            lim = 0;
`endif
            exp_burst.push_back({ba, 4'(b)});
            ba  = ba + 64'(64 * b);
            rem = rem - b;
        end
        exp_compl.push_back({a, len, desc});
        @(negedge clk);
        req_addr = a; req_length = len; req_desc_addr = desc; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("req_accepted", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_flit.size() + exp_compl.size() + exp_burst.size() + rd_q.size()) != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_empty", exp_flit.size() + exp_compl.size() + exp_burst.size() + rd_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_sw_reset();
        @(negedge clk); sw_reset = 1'b1;
        @(negedge clk); sw_reset = 1'b0;
        check_val("sw_reset_stall", rd_stall_cnt, 0);
        check_val("sw_reset_err", rsp_err_cnt, 0);
    endtask

    // BAS slave model and output/completion monitors
    initial begin
        logic        prev_stalled = 1'b0, prev_hold = 1'b0;
        logic [63:0] prev_addr = '0;
        logic [3:0]  prev_bc = '0;
        logic [513:0] prev_flit = '0, ef;
        logic [67:0]  eb;
        logic [159:0] ec;
        logic [63:0]  a;
        pcie_bas_waitrequest = 1'b0; pcie_bas_readdatavalid = 1'b0;
        pcie_bas_readdata = '0; pcie_bas_response = '0;
        out_ready = 1'b0; compl_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                a = rd_q.pop_front();
                pcie_bas_readdatavalid = 1'b1;
                pcie_bas_readdata = data_of(a);
                pcie_bas_response = (a == err_addr) ? 2'd2 : 2'd0;
            end else begin
                pcie_bas_readdatavalid = 1'b0;
                pcie_bas_response = 2'd0;
            end
            if (pcie_bas_read && stall_left > 0 && burst_seen == stall_target) begin
                pcie_bas_waitrequest = 1'b1;
                stall_left--;
            end else begin
                pcie_bas_waitrequest = 1'b0;
            end
            if (pcie_bas_read && prev_stalled) begin
                check_val("bas_addr_stable", pcie_bas_address, prev_addr);
                check_val("bas_bc_stable", pcie_bas_burstcount, prev_bc);
            end
            prev_stalled = pcie_bas_read && pcie_bas_waitrequest;
            prev_addr = pcie_bas_address;
            prev_bc = pcie_bas_burstcount;
            if (pcie_bas_read && !pcie_bas_waitrequest) begin
                eb = (exp_burst.size() != 0) ? exp_burst.pop_front() : '1;
                check_val("burst", {pcie_bas_address, pcie_bas_burstcount}, eb);
                issued_flits += longint'(pcie_bas_burstcount);
                check_val("credit_bound", (issued_flits - popped_flits) <= RESP_DEPTH, 1);
                for (int i = 0; i < int'(pcie_bas_burstcount); i++)
                    rd_q.push_back(pcie_bas_address + 64'(64 * i));
                burst_seen++;
            end
            out_ready   = (out_mode == 0) || (out_mode == 2 && $urandom_range(0, 1) == 1);
            compl_ready = (compl_mode == 0) || (compl_mode == 2 && $urandom_range(0, 1) == 1);
            #1;
            if (prev_hold) begin
                check_val("out_hold_valid", out_valid, 1);
                check_val("out_hold_flit", {out_data, out_sop, out_eop}, prev_flit);
            end
            if (out_valid && out_eop)
                check_val("eop_needs_empty_compl", compl_valid, 0);
            if (out_valid && out_ready) begin
                ef = (exp_flit.size() != 0) ? exp_flit.pop_front() : '1;
                check_val("flit", {out_data, out_sop, out_eop}, ef);
                popped_flits++;
            end
            prev_hold = out_valid && !out_ready;
            prev_flit = {out_data, out_sop, out_eop};
            if (compl_valid && compl_ready) begin
                ec = (exp_compl.size() != 0) ? exp_compl.pop_front() : '1;
                check_val("compl", {compl_transfer_addr, compl_length, compl_descriptor_addr}, ec);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        longint base;
        rst = 1'b1; sw_reset = 1'b0; req_valid = 1'b0;
        req_addr = '0; req_length = '0; req_desc_addr = '0;
        repeat (3) @(negedge clk);
        check_val("rst_read", pcie_bas_read, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_compl_valid", compl_valid, 0);
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_stall_cnt", rd_stall_cnt, 0);
        check_val("rst_err_cnt", rsp_err_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_req_ready", req_ready, 1);
        check_val("byteenable", pcie_bas_byteenable, {64{1'b1}});
        check_val("write_tied", pcie_bas_write, 0);

        // V1, V2, V3
        send(64'h1000, 32'd64, 64'hD000_0001);
        drain();
        send(64'h2000, 32'd1000, 64'hD000_0002);
        drain();
        send(64'h0FC0, 32'd512, 64'hD000_0003);
        drain();

        // V4: stall the second burst of a two-burst transfer for 5 cycles
        pulse_sw_reset();
        stall_target = burst_seen + 1;
        stall_left = 5;
        send(64'h8000, 32'd1024, 64'hD000_0004);
        drain();
        check_val("rd_stall_cnt", rd_stall_cnt, 5);

        // V5a: credits exhaust with output stalled
        out_mode = 1;
        base = issued_flits;
        send(64'h10000, 32'd8192, 64'hD000_0005);
        repeat (300) @(negedge clk);
        check_val("credit_limit_flits", issued_flits - base, RESP_DEPTH);
        check_val("credit_no_read", pcie_bas_read, 0);
        out_mode = 2;
        drain();
        out_mode = 0;

        // V5b: eop held until completion register drains
        compl_mode = 1;
        base = popped_flits;
        send(64'h3000, 32'd64, 64'hD000_0006);
        send(64'h3040, 32'd128, 64'hD000_0007);
        repeat (50) @(negedge clk);
        check_val("eop_held_valid", out_valid, 0);
        check_val("eop_held_compl", compl_valid, 1);
        check_val("eop_held_popped", popped_flits - base, 2);
        compl_mode = 0;
        drain();

        // V6: zero-length transfer and error response
        pulse_sw_reset();
        err_addr = 64'h5040;
        base = issued_flits;
        send(64'h5000, 32'd0, 64'hD000_0008);
        drain();
        check_val("zero_len_no_read", issued_flits - base, 0);
        send(64'h5000, 32'd192, 64'hD000_0009);
        drain();
        check_val("rsp_err_cnt", rsp_err_cnt, 1);
        err_addr = '1;

        // mixed traffic with random backpressure
        out_mode = 2;
        compl_mode = 2;
        for (int i = 0; i < 12; i++)
            send(64'h40000 + {50'd0, 8'($urandom_range(0, 255)), 6'd0},
                 32'($urandom_range(0, 700)), 64'hE000_0000 + 64'(i));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_to_fpga_dma.md
CPU_TO_FPGA_DMA -- requirements
Module: cpu_to_fpga_dma

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: maximum flits per PCIe BAS read burst (1..8).
REQ-002 SHALL have parameter RESP_DEPTH, default 64: response buffer depth in flits, which is also the read credit pool.
REQ-003 SHALL have parameter COMPL_DEPTH, default 4: maximum number of transfers accepted but not yet completed.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sw_reset  in  1  counter reset
- req_addr  in  64  host byte address, 64 B aligned
- req_length  in  32  transfer length in bytes
- req_desc_addr  in  64  host address for the completion descriptor
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high together with req_valid
- pcie_bas_waitrequest  in  1  BAS stall
- pcie_bas_address  out  64  read address
- pcie_bas_byteenable  out  64  byte enables
- pcie_bas_read  out  1  read command
- pcie_bas_burstcount  out  4  burst length in flits
- pcie_bas_readdata  in  512  read data
- pcie_bas_readdatavalid  in  1  read data valid
- pcie_bas_response  in  2  response status
- pcie_bas_write  out  1  write command, tied 0
- out_data  out  512  packet flit
- out_sop  out  1  first flit of a transfer
- out_eop  out  1  last flit of a transfer
- out_valid  out  1  flit valid
- out_ready  in  1  flit consumed
- compl_transfer_addr  out  64  completed transfer's req_addr
- compl_length  out  32  completed transfer's req_length
- compl_descriptor_addr  out  64  completed transfer's req_desc_addr
- compl_valid  out  1  completion valid
- compl_ready  in  1  completion consumed
- rd_stall_cnt  out  32  cycles with pcie_bas_read high and pcie_bas_waitrequest high
- rsp_err_cnt  out  32  flits received with a nonzero pcie_bas_response

Function
REQ-005 SHALL compute the flit count of a transfer as ceil(req_length/64), with req_length 0 giving 0 flits.
REQ-006 SHALL use FSM states IDLE, ISSUE and HOLD.
- IDLE: req_ready = 1 when the completion-tracking FIFO is not full; on accept, go to ISSUE, or stay in IDLE if the flit count is 0.
- ISSUE: compute the burst as the minimum of remaining flits, MAX_BURST and the page limit (REQ-017); issue it only when free credits are at least the burst size; then enter HOLD.
- HOLD: keep pcie_bas_read, address and burstcount stable until waitrequest is low; then subtract the burst from the remaining flits; go to ISSUE if flits remain, otherwise IDLE.
REQ-007 SHALL present pcie_bas_read for exactly one cycle with waitrequest low per burst, and keep pcie_bas_byteenable all-ones.
REQ-008 SHALL advance the burst address by 64 times the burst size, with 64-bit wrap.
REQ-009 SHALL decrement credits by the burst size at issue, and increment them by 1 per flit popped to out_*; credits SHALL never exceed RESP_DEPTH.
REQ-010 SHALL push each readdatavalid flit into the response FIFO in arrival order; responses are in order.
REQ-011 SHALL tag flits with sop on the first flit and eop on the last flit of each transfer; a 1-flit transfer has sop and eop both set.
REQ-012 SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-013 SHALL assert out_valid on an eop flit only when the completion output register is empty.
- When the eop flit is accepted, the tracked request moves to compl_* and compl_valid goes high on the next cycle.
- A 0-flit transfer moves to compl_* directly once the register is empty.
REQ-014 SHALL hold compl_* stable until compl_ready, and clear compl_valid in the cycle after the handshake.
REQ-015 SHALL increment rsp_err_cnt for each flit received with a nonzero response, and still forward that flit.
REQ-016 SHALL saturate both counters at 2^32-1, and clear them on sw_reset without affecting the datapath.

Reset
REQ-018 SHALL, on rst:
- drive pcie_bas_read, out_valid, compl_valid and req_ready to 0;
- set all counters to 0 and credits to RESP_DEPTH;
- empty all FIFOs;
- enter IDLE.
REQ-019 SHALL abandon a reset mid-transfer with no partial completion; readdatavalid flits arriving while no burst is outstanding SHALL be discarded.

Configuration
REQ-017 SHALL implement macro C2F_PAGE_SPLIT_EN:
- defined: no burst may cross a 4 KiB host page, so the page limit = (4096 - (address mod 4096))/64;
- undefined: the page limit is MAX_BURST.

Verification
REQ-020 SHALL cover these directed scenarios:
- V1: addr 0x1000, length 64 -> one read with burstcount 1; one flit with sop=eop=1; completion with length 64.
- V2: addr 0x2000, length 1000 -> bursts of 8 and 8 flits; 16 flits out, sop on flit 0 and eop on flit 15.
- V3: addr 0x0FC0, length 512, with C2F_PAGE_SPLIT_EN -> bursts 1@0x0FC0 and 7@0x1000; without the macro -> a single burst of 8.
- V4: waitrequest held for 5 cycles during burst 2 -> address and burstcount stable throughout; rd_stall_cnt = 5.
- V5: out_ready low, RESP_DEPTH 64, length 8192 -> at most 64 flits outstanding and no read issued without credit; compl_ready low -> the eop flit is held until the completion register drains.
- V6: length 0 -> no reads issued and one completion produced; response=2 on one flit -> rsp_err_cnt = 1 and the data is still forwarded.
